// File: rtl/mem_write_arbiter_pkg.sv
// Shared constants and the packed write-entry type for mem_write_arbiter.
// Optional round-robin arbitration is selected with ARB_ROUND_ROBIN_EN.
package mem_write_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GRANT_A = 2'd1;
    localparam logic [1:0] ARB_GRANT_B = 2'd2;
    localparam logic [1:0] ARB_LOCK_B  = 2'd3;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    localparam int WR_ENTRY_W = 72;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  dmem_wea;
        logic [3:0]  imem_wea;
    } wr_entry_t;

    function automatic logic has_mask(wr_entry_t e);
        return |{e.dmem_wea, e.imem_wea};
    endfunction

endpackage

// File: rtl/mem_write_arbiter_if.sv
// Request ports (CPU store path A, loader B) and the DMEM/IMEM write ports.
// slave = arbiter side, master = requester/memory model side.
interface mem_write_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_addr;
    logic [31:0] a_din;
    logic [3:0]  a_dmem_wea;
    logic [3:0]  a_imem_wea;

    logic        b_valid;
    logic        b_ready;
    logic        b_lock;
    logic [31:0] b_addr;
    logic [31:0] b_din;
    logic [3:0]  b_dmem_wea;
    logic [3:0]  b_imem_wea;

    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_din;
    logic [3:0]        dmem_wea;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_din;
    logic [3:0]        imem_wea;
    logic              buf_empty;

    modport slave (
        input  a_valid, a_addr, a_din, a_dmem_wea, a_imem_wea,
        input  b_valid, b_lock, b_addr, b_din, b_dmem_wea, b_imem_wea,
        output a_ready, b_ready,
        output dmem_addr, dmem_din, dmem_wea,
        output imem_addr, imem_din, imem_wea, buf_empty
    );

    modport master (
        output a_valid, a_addr, a_din, a_dmem_wea, a_imem_wea,
        output b_valid, b_lock, b_addr, b_din, b_dmem_wea, b_imem_wea,
        input  a_ready, b_ready,
        input  dmem_addr, dmem_din, dmem_wea,
        input  imem_addr, imem_din, imem_wea, buf_empty
    );

endinterface

// File: rtl/mem_write_arbiter_wr_post_fifo.sv
// Posted-write FIFO for CPU stores: DEPTH x W, power-of-two depth,
// synchronous active-low reset of pointers and count.
module wr_post_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 72
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop)  rp <= rp + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; stale entries are never read past count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Shares DMEM/IMEM byte-write ports between CPU posted stores (A) and loader (B).
// ARB_ROUND_ROBIN_EN selects round-robin; default is fixed priority A over B.
module mem_write_arbiter
    import mem_write_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_write_arbiter_if.slave   bus
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    wr_entry_t     a_ent;
    wr_entry_t     b_ent;
    wr_entry_t     f_ent;
    wr_entry_t     sel;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [1:0]    state_d;
    logic          last_grant;
    logic          gnt_a;
    logic          gnt_b;
    logic          gnt;
    logic          lock_hold;
    logic          win_b;
    logic          unused_bits;

    assign a_ent = {bus.a_addr, bus.a_din, bus.a_dmem_wea, bus.a_imem_wea};
    assign b_ent = {bus.b_addr, bus.b_din, bus.b_dmem_wea, bus.b_imem_wea};

    // Mask-less CPU stores complete the handshake but never occupy a slot.
    assign push = bus.a_valid && bus.a_ready && has_mask(a_ent);

    wr_post_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (WR_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (a_ent),
        .pop   (pop),
        .dout  (f_ent),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.a_ready   = !full;
    assign bus.buf_empty = (count == '0);

`ifdef ARB_ROUND_ROBIN_EN
    assign win_b = (last_grant == GNT_A);
`else
    assign win_b = 1'b0;
`endif

    assign lock_hold = ((state == ARB_GRANT_B) || (state == ARB_LOCK_B))
                       && bus.b_lock && bus.b_valid;

    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        state_d = ARB_IDLE;
        if (lock_hold) begin
            gnt_b = 1'b1;
        end else if (!empty && bus.b_valid) begin
            gnt_b = win_b;
            gnt_a = !win_b;
        end else begin
            gnt_a = !empty;
            gnt_b = bus.b_valid;
        end
        unique case (1'b1)
            lock_hold:              state_d = ARB_LOCK_B;
            gnt_a:                  state_d = ARB_GRANT_A;
            (gnt_b && !lock_hold):  state_d = ARB_GRANT_B;
            default:                state_d = ARB_IDLE;
        endcase
    end

    assign bus.b_ready = gnt_b;
    assign pop         = gnt_a;
    assign gnt         = gnt_a || gnt_b;
    assign sel         = gnt_b ? b_ent : f_ent;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ARB_IDLE;
            last_grant    <= GNT_A;
            bus.dmem_addr <= '0;
            bus.dmem_din  <= '0;
            bus.dmem_wea  <= '0;
            bus.imem_addr <= '0;
            bus.imem_din  <= '0;
            bus.imem_wea  <= '0;
        end else begin
            state        <= state_d;
            bus.dmem_wea <= gnt ? sel.dmem_wea : 4'b0;
            bus.imem_wea <= gnt ? sel.imem_wea : 4'b0;
            if (gnt) last_grant <= gnt_b ? GNT_B : GNT_A;
            // Each memory port only moves addr/din when it is really written.
            if (gnt && |sel.dmem_wea) begin
                bus.dmem_addr <= sel.addr[ADDR_W+1:2];
                bus.dmem_din  <= sel.din;
            end
            if (gnt && |sel.imem_wea) begin
                bus.imem_addr <= sel.addr[ADDR_W+1:2];
                bus.imem_din  <= sel.din;
            end
        end
    end

    assign unused_bits = ^{sel.addr[31:ADDR_W+2], sel.addr[1:0], last_grant};

endmodule
